// File: rtl/exec_alu_unit.sv
// Execute-stage ALU with a private 4-entry register file.
// Load/store/add/sub complete in one cycle. Multiply uses iterative
// shift-add and divide uses restoring division; each takes WIDTH cycles.
// The result is held until the consumer takes it.
module exec_alu_unit #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [1:0]       rd,
    input  logic [WIDTH-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_rd,
    output logic [WIDTH-1:0] out_result,
    output logic             out_dz,
    output logic             out_ill,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] regs [4];
    logic [1:0]       rd_q;
    logic [CW-1:0]    cnt;

    // Shared iteration registers:
    //   a_q:   multiplicand (shifted left) or dividend/quotient (shifted left).
    //   b_q:   multiplier (shifted right) or divisor (held constant).
    //   acc_q: partial product or partial remainder.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;

    logic             accept;
    logic             single_op;
    logic [WIDTH-1:0] single_res;
    logic             single_dz;
    logic             single_ill;
    logic             single_wr;

    logic [WIDTH-1:0] mul_acc_step;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_rem_step;
    logic [WIDTH-1:0] div_quo_step;

    // Handshake signals. out_valid is true exactly while in DONE.
    always_comb begin
        out_valid = (state == DONE);
        in_ready  = (state == IDLE) && !out_valid;
        accept    = in_valid && in_ready;
        single_op = !((opcode == OP_MUL) || ((opcode == OP_DIV) && (operand != '0)));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL)                           state_next = MUL;
                    else if ((opcode == OP_DIV) && (operand != '0)) state_next = DIV;
                    else                                            state_next = DONE;
                end
            end
            MUL, DIV: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result of the single-cycle operations. This also covers divide-by-zero
    // and illegal opcodes.
    always_comb begin
        single_res = '0;
        single_dz  = 1'b0;
        single_ill = 1'b0;
        single_wr  = 1'b0;
        case (opcode)
            OP_LOAD: begin
                single_res = operand;
                single_wr  = 1'b1;
            end
            OP_STORE: single_res = regs[rd];
            OP_ADD: begin
                single_res = regs[rd] + operand;
                single_wr  = 1'b1;
            end
            OP_SUB: begin
                single_res = regs[rd] - operand;
                single_wr  = 1'b1;
            end
            OP_MUL: single_res = '0;
            OP_DIV: begin
                single_res = '1;
                single_dz  = 1'b1;
            end
            default: single_ill = 1'b1;
        endcase
    end

    // One step of the shift-add multiply and one step of the restoring divide.
    always_comb begin
        mul_acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
        div_shifted  = {acc_q, a_q[WIDTH-1]};
        div_trial    = div_shifted - {1'b0, b_q};
        if (!div_trial[WIDTH]) begin
            div_rem_step = div_trial[WIDTH-1:0];
            div_quo_step = {a_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_step = div_shifted[WIDTH-1:0];
            div_quo_step = {a_q[WIDTH-2:0], 1'b0};
        end
    end

    // Datapath: operand capture, iteration, result and register-file write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
            rd_q       <= '0;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            out_rd     <= '0;
            out_result <= '0;
            out_dz     <= 1'b0;
            out_ill    <= 1'b0;
        end else if (accept) begin
            rd_q  <= rd;
            cnt   <= '0;
            a_q   <= regs[rd];
            b_q   <= operand;
            acc_q <= '0;
            if (single_op) begin
                out_rd     <= rd;
                out_result <= single_res;
                out_dz     <= single_dz;
                out_ill    <= single_ill;
                if (single_wr) regs[rd] <= single_res;
            end
        end else if (state == MUL) begin
            cnt   <= cnt + CW'(1);
            acc_q <= mul_acc_step;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            if (cnt == LAST) begin
                out_rd       <= rd_q;
                out_result   <= mul_acc_step;
                out_dz       <= 1'b0;
                out_ill      <= 1'b0;
                regs[rd_q]   <= mul_acc_step;
            end
        end else if (state == DIV) begin
            cnt   <= cnt + CW'(1);
            acc_q <= div_rem_step;
            a_q   <= div_quo_step;
            if (cnt == LAST) begin
                out_rd       <= rd_q;
                out_result   <= div_quo_step;
                out_dz       <= 1'b0;
                out_ill      <= 1'b0;
                regs[rd_q]   <= div_quo_step;
            end
        end
    end

    // Debug read port.
    always_comb begin
        dbg_data = regs[dbg_sel];
    end

endmodule

// File: tb/tb_exec_alu_unit.sv
// Self-checking bench for exec_alu_unit. The bench keeps an
// arithmetic reference model of the register file and the opcode rules.
module tb_exec_alu_unit;

    localparam int WIDTH = 12;
    localparam int unsigned MASK = 32'hFFF;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [1:0]        rd;
    logic [WIDTH-1:0]  operand;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_rd;
    logic [WIDTH-1:0]  out_result;
    logic              out_dz;
    logic              out_ill;
    logic [1:0]        dbg_sel;
    logic [WIDTH-1:0]  dbg_data;

    int tests_run;
    int tests_failed;
    int unsigned model_r [4];

    exec_alu_unit #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .rd         (rd),
        .operand    (operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result),
        .out_dz     (out_dz),
        .out_ill    (out_ill),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: applies one operation to model_r and returns the
    // expected result, flags and latency in cycles.
    function automatic void model(input int unsigned op, input int unsigned r, input int unsigned v,
                                  output int unsigned res, output bit dz, output bit ill,
                                  output int lat);
        res = 0; dz = 0; ill = 0; lat = 1;
        case (op)
            0: begin res = v; model_r[r] = res; end
            1: res = model_r[r];
            2: begin res = (model_r[r] + v) & MASK; model_r[r] = res; end
            3: begin res = (model_r[r] - v) & MASK; model_r[r] = res; end
            4: begin res = (model_r[r] * v) & MASK; model_r[r] = res; lat = WIDTH + 1; end
            5: begin
                if (v == 0) begin res = MASK; dz = 1; end
                else begin res = model_r[r] / v; model_r[r] = res; lat = WIDTH + 1; end
            end
            default: ill = 1;
        endcase
    endfunction

    // Issue one operation, scramble inputs after acceptance, and wait
    // (bounded) for the result.
    task automatic issue(input logic [2:0] op, input logic [1:0] r, input logic [WIDTH-1:0] v,
                         output logic [WIDTH-1:0] res, output logic dz, output logic ill,
                         output logic [1:0] ord, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin tick(); w++; end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1; opcode = op; rd = r; operand = v;
        tick();
        in_valid = 1'b0;
        opcode = 3'($urandom); rd = 2'($urandom); operand = WIDTH'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        res = out_result; dz = out_dz; ill = out_ill; ord = out_rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        tests_run++;
        if ({out_valid, out_rd, out_result, out_dz, out_ill} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%0b rd=%0d res=%h dz=%0b ill=%0b required all 0",
                     out_valid, out_rd, out_result, out_dz, out_ill);
        end
        reset = 1'b0;
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            model_r[i] = 0;
            dbg_sel = 2'(i); #1;
            tests_run++;
            if (dbg_data !== '0) begin
                tests_failed++;
                $display("FAIL reset_reg%0d: got %h required 000", i, dbg_data);
            end
        end
    endtask

    task automatic test_load_mul();
        logic [WIDTH-1:0] res; logic dz, ill; logic [1:0] ord; int lat;
        int unsigned er; bit edz, eill; int elat;
        model(0, 0, 6, er, edz, eill, elat);
        issue(3'd0, 2'd0, 12'h006, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'h006 || lat != 1) begin
            tests_failed++;
            $display("FAIL load_r0: got res=%h lat=%0d required 006 lat=1", res, lat);
        end
        model(4, 0, 4, er, edz, eill, elat);
        issue(3'd4, 2'd0, 12'h004, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'h018 || lat != 13 || dz !== 1'b0 || ill !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_r0: got res=%h lat=%0d dz=%0b ill=%0b required 018 lat=13 0 0", res, lat, dz, ill);
        end
        dbg_sel = 2'd0; #1;
        tests_run++;
        if (dbg_data !== 12'h018) begin
            tests_failed++;
            $display("FAIL mul_dbg_r0: got %h required 018", dbg_data);
        end
    endtask

    task automatic test_div();
        logic [WIDTH-1:0] res; logic dz, ill; logic [1:0] ord; int lat;
        int unsigned er; bit edz, eill; int elat;
        model(0, 1, 13, er, edz, eill, elat);
        issue(3'd0, 2'd1, 12'h00D, res, dz, ill, ord, lat);
        model(5, 1, 4, er, edz, eill, elat);
        issue(3'd5, 2'd1, 12'h004, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'h003 || dz !== 1'b0 || lat != 13) begin
            tests_failed++;
            $display("FAIL div_r1: got res=%h dz=%0b lat=%0d required 003 0 lat=13", res, dz, lat);
        end
        model(5, 1, 0, er, edz, eill, elat);
        issue(3'd5, 2'd1, 12'h000, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'hFFF || dz !== 1'b1 || lat != 1) begin
            tests_failed++;
            $display("FAIL div_zero: got res=%h dz=%0b lat=%0d required FFF 1 lat=1", res, dz, lat);
        end
        dbg_sel = 2'd1; #1;
        tests_run++;
        if (dbg_data !== 12'h003) begin
            tests_failed++;
            $display("FAIL div_zero_r1_kept: got %h required 003", dbg_data);
        end
    endtask

    task automatic test_wrap_ill();
        logic [WIDTH-1:0] res; logic dz, ill; logic [1:0] ord; int lat;
        int unsigned er; bit edz, eill; int elat;
        model(0, 2, MASK, er, edz, eill, elat);
        issue(3'd0, 2'd2, 12'hFFF, res, dz, ill, ord, lat);
        model(2, 2, 1, er, edz, eill, elat);
        issue(3'd2, 2'd2, 12'h001, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'h000) begin
            tests_failed++;
            $display("FAIL add_wrap: got %h required 000", res);
        end
        model(3, 2, 1, er, edz, eill, elat);
        issue(3'd3, 2'd2, 12'h001, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'hFFF) begin
            tests_failed++;
            $display("FAIL sub_wrap: got %h required FFF", res);
        end
        model(7, 2, 5, er, edz, eill, elat);
        issue(3'd7, 2'd2, 12'h005, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'h000 || ill !== 1'b1 || dz !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal: got res=%h ill=%0b dz=%0b required 000 1 0", res, ill, dz);
        end
        dbg_sel = 2'd2; #1;
        tests_run++;
        if (dbg_data !== 12'hFFF) begin
            tests_failed++;
            $display("FAIL illegal_r2_kept: got %h required FFF", dbg_data);
        end
    endtask

    task automatic test_store();
        logic [WIDTH-1:0] res; logic dz, ill; logic [1:0] ord; int lat;
        int unsigned er; bit edz, eill; int elat;
        model(0, 1, 8, er, edz, eill, elat);
        issue(3'd0, 2'd1, 12'h008, res, dz, ill, ord, lat);
        model(1, 1, 0, er, edz, eill, elat);
        issue(3'd1, 2'd1, 12'h3C3, res, dz, ill, ord, lat);
        tests_run++;
        if (res !== 12'h008 || ord !== 2'd1) begin
            tests_failed++;
            $display("FAIL store_r1: got res=%h rd=%0d required 008 rd=1", res, ord);
        end
        dbg_sel = 2'd1; #1;
        tests_run++;
        if (dbg_data !== 12'h008) begin
            tests_failed++;
            $display("FAIL store_r1_kept: got %h required 008", dbg_data);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] res; logic dz, ill; logic [1:0] ord; int lat;
        int unsigned er; bit edz, eill; int elat;
        tick();
        out_ready = 1'b0;
        model(0, 0, 32'h5A5, er, edz, eill, elat);
        issue(3'd0, 2'd0, 12'h5A5, res, dz, ill, ord, lat);
        in_valid = 1'b1; opcode = 3'd0; rd = 2'd0; operand = 12'h111;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_result !== 12'h5A5 || out_rd !== 2'd0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold c%0d: got v=%0b res=%h rd=%0d in_ready=%0b required 1 5A5 0 0",
                         c, out_valid, out_result, out_rd, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: got v=%0b in_ready=%0b required 0 1", out_valid, in_ready);
        end
        dbg_sel = 2'd0; #1;
        tests_run++;
        if (dbg_data !== 12'h5A5) begin
            tests_failed++;
            $display("FAIL stall_ignored_op: got %h required 5A5", dbg_data);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [WIDTH-1:0] res; logic dz, ill; logic [1:0] ord; int lat;
        int unsigned er; bit edz, eill; int elat;
        int seen;
        model(0, 3, 5, er, edz, eill, elat);
        issue(3'd0, 2'd3, 12'h005, res, dz, ill, ord, lat);
        tick();
        in_valid = 1'b1; opcode = 3'd4; rd = 2'd3; operand = 12'h007;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) model_r[i] = 0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_mul_reset: got in_ready=%0b v=%0b required 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid) seen++;
        end
        dbg_sel = 2'd3; #1;
        tests_run++;
        if (seen != 0 || dbg_data !== '0) begin
            tests_failed++;
            $display("FAIL mid_mul_abandon: got valid_cycles=%0d r3=%h required 0 000", seen, dbg_data);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] res; logic dz, ill; logic [1:0] ord; int lat;
        int unsigned er; bit edz, eill; int elat;
        int unsigned op, r, v;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 7);
            r  = $urandom_range(0, 3);
            v  = ($urandom_range(0, 3) == 0) ? 0 : ($urandom & MASK);
            if (n < 4) op = 0;
            model(op, r, v, er, edz, eill, elat);
            issue(3'(op), 2'(r), WIDTH'(v), res, dz, ill, ord, lat);
            dbg_sel = 2'(r); #1;
            tests_run++;
            if (res !== WIDTH'(er) || dz !== edz || ill !== eill || ord !== 2'(r) || lat != elat
                || dbg_data !== WIDTH'(model_r[r])) begin
                tests_failed++;
                $display("FAIL random_op%0d op=%0d: got res=%h dz=%0b ill=%0b rd=%0d lat=%0d reg=%h required %h %0b %0b %0d %0d %h",
                         n, op, res, dz, ill, ord, lat, dbg_data, er, edz, eill, r, elat, model_r[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned er; bit edz, eill; int elat;
        int accepted;
        tick();
        out_ready = 1'b1;
        accepted = 0;
        in_valid = 1'b1; opcode = 3'd0;
        rd = 2'($urandom); operand = WIDTH'($urandom);
        for (int c = 0; c < 10; c++) begin
            if (in_ready) begin
                accepted++;
                model(0, rd, operand, er, edz, eill, elat);
            end
            tick();
            rd = 2'($urandom); operand = WIDTH'($urandom);
        end
        in_valid = 1'b0;
        tests_run++;
        if (accepted != 5) begin
            tests_failed++;
            $display("FAIL b2b_rate: got %0d accepts in 10 cycles required 5", accepted);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i); #1;
            tests_run++;
            if (dbg_data !== WIDTH'(model_r[i])) begin
                tests_failed++;
                $display("FAIL b2b_reg%0d: got %h required %h", i, dbg_data, model_r[i]);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        clock = 1'b0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        opcode = '0;
        rd = '0;
        operand = '0;
        dbg_sel = '0;
        test_reset();
        test_load_mul();
        test_div();
        test_wrap_ill();
        test_store();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exec_alu_unit.md
EXEC_ALU_UNIT -- requirements
Module: exec_alu_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 12, datapath and register width in bits; all values below assume 12.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  decode stage presents an operation.
REQ-005 SHALL have port: in_ready  output  1  unit can accept an operation this cycle.
REQ-006 SHALL have port: opcode  input  3  0 load, 1 store, 2 add, 3 sub, 4 mul, 5 div, 6-7 illegal.
REQ-007 SHALL have port: rd  input  2  destination/source register index R0..R3.
REQ-008 SHALL have port: operand  input  WIDTH  memory operand (MBR value) from decode stage.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: out_rd  output  2  register index of the result.
REQ-012 SHALL have port: out_result  output  WIDTH  result value.
REQ-013 SHALL have port: out_dz  output  1  divide-by-zero flag for the current result.
REQ-014 SHALL have port: out_ill  output  1  illegal-opcode flag for the current result.
REQ-015 SHALL have port: dbg_sel  input  2  register file read select.
REQ-016 SHALL have port: dbg_data  output  WIDTH  combinational read of R[dbg_sel].

Function
REQ-017 SHALL hold four WIDTH-bit registers R0..R3, internal to the unit.
REQ-018 SHALL implement states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE) and not out_valid.
REQ-019 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1, latching opcode, rd, operand.
REQ-020 SHALL, for load/add/sub/store/illegal/div-by-zero, go IDLE->DONE, with out_valid high on the first cycle after acceptance.
REQ-021 load: result = operand; R[rd] written.
REQ-022 store: result = R[rd]; register file unchanged.
REQ-023 add/sub: result = (R[rd] +/- operand) mod 2^WIDTH, unsigned, wrap-around without flag; R[rd] written.
REQ-024 mul: iterative shift-add, one bit per cycle, WIDTH cycles in MUL; result = low WIDTH bits of R[rd]*operand; out_valid on cycle WIDTH+1 after acceptance; R[rd] written.
REQ-025 div: restoring division, one quotient bit per cycle, WIDTH cycles in DIV; result = floor(R[rd]/operand), unsigned; out_valid on cycle WIDTH+1 after acceptance; R[rd] written.
REQ-026 div with operand==0: skips DIV state; result 12'hFFF; out_dz=1; R[rd] unchanged.
REQ-027 illegal opcode: result 0; out_ill=1; register file unchanged.
REQ-028 SHALL write R[rd] on the same edge that raises out_valid; dbg_data reflects the new value in that following cycle.
REQ-029 SHALL hold out_valid, out_rd, out_result, out_dz, out_ill stable in DONE until out_valid and out_ready on a rising edge, then return to IDLE with out_valid=0.
REQ-030 SHALL ignore in_valid while in_ready=0; operand/opcode changes during MUL/DIV SHALL NOT affect the result.
REQ-031 SHALL use the R[rd] value sampled at acceptance for mul/div operands.
REQ-032 back-to-back single-cycle operations SHALL achieve one accepted operation every 2 cycles when out_ready is held 1.

Reset
REQ-033 On reset=1 at a rising edge: state=IDLE, R0..R3=0, out_valid=0, out_rd=0, out_result=0, out_dz=0, out_ill=0.
REQ-034 Reset SHALL take priority over acceptance, iteration and output handshake; reset during MUL/DIV/DONE abandons the operation with no register write and no out_valid.
REQ-035 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-036 load R0 6, then mul R0 by 4, out_ready=1 -> results 0x006 (1 cycle) then 0x018 (13 cycles after acceptance); dbg_sel=0 shows 0x018.
REQ-037 load R1 0x00D, div R1 by 0x004 -> result 0x003, out_dz=0; then div R1 by 0 -> result 0xFFF, out_dz=1, R1 stays 0x003.
REQ-038 load R2 0xFFF, add R2 1 -> result 0x000 (wrap); sub R2 1 -> 0xFFF; opcode 7 -> out_ill=1, result 0, R2 unchanged.
REQ-039 out_ready held 0 for 5 cycles after a result -> out_valid and outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> accept resumes next cycle.
REQ-040 reset asserted 5 cycles into a mul on R3 -> no out_valid, R3=0, in_ready=1 after reset release.
REQ-041 store R1 after load R1 0x008 -> out_result 0x008, R1 unchanged.
